sseg_scan_driver: RTL and testbench
===================================

# sseg_scan_driver

Time-multiplexed four-digit seven-segment driver downstream of the processor datapath's display selector. Consumes the 32-bit value chosen by `display_control` (ALU result, register A or register B), shows one 16-bit half as four hex digits, and scans the digits at a fixed refresh rate. It latches a frame-stable snapshot so a value changing every instruction never tears across digits. Its outputs drive the board's common-anode display directly.

## Interface
- `REFRESH_DIV`, 100000: clock cycles each digit stays lit; legal range 2..2^20.
- `clk`  in  1  system clock, shared with the datapath.
- `reset`  in  1  asynchronous, active-low reset.
- `display_value`  in  32  value from the datapath display mux.
- `half_sel`  in  1  0 shows `display_value[15:0]`, 1 shows `[31:16]`.
- `blank_en`  in  1  1 enables leading-zero blanking.
- `sseg_cathode`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `sseg_anode`  out  4  digit enables, bit 0 = rightmost digit, active-low.
- `frame_tick`  out  1  one-cycle pulse when a new snapshot is latched.

## Operation
- **Reset state (`reset`=0, asynchronous):**
  - prescaler=0, digit index=0, snapshot=16'h0, `pending`=1.
  - Outputs: `sseg_anode`=4'b1111, `sseg_cathode`=7'b1111111, `frame_tick`=0.
- **Prescaler:** counts 0..REFRESH_DIV-1 and wraps to 0. The terminal count is the digit tick.
- **Digit index:** advances on each digit tick, 0→1→2→3→0.
- **Snapshot latch:**
  - Loads the selected half of `display_value` and the value of `blank_en` on the first edge after reset release (clears `pending`).
  - Also loads on every digit tick where the index goes 3→0.
  - `frame_tick` asserts in the cycle after each load.
  - `half_sel`, `blank_en` and `display_value` are sampled only at load time.
- **Decode:** the snapshot nibble for the current index is decoded by hex_to_sseg (full 0–F set):
  - 0=1000000, 8=0000000, A=0001000, F=0001110.
- **Blanking:** when the latched blank_en=1, a digit above the most significant non-zero nibble is blanked: anode bit high, cathode all ones. Digit 0 is never blanked, so 0x0000 shows "0".
- **Anode:** exactly one anode bit is low for each displayed digit, never more than one.
- **Output registers:** `sseg_anode` and `sseg_cathode` load from the pre-edge index and snapshot. While `pending`=1 they load the blank pattern.

## Timing
- Edge 1 after release: snapshot loads, outputs stay blank.
- Edge 2: `sseg_anode`=1110 showing digit 0; `frame_tick`=1 for this cycle.
- Each digit is lit for exactly REFRESH_DIV cycles; a frame is 4×REFRESH_DIV cycles.
- Each output lags the index change by 1 cycle.
- Changes to `display_value` between loads have no visible effect until the next frame.
- Reset asserted mid-frame returns all state to reset values immediately (asynchronously). Scanning restarts at digit 0 after release.
- A digit tick at index 3 coinciding with a `display_value` change latches the post-change (current-cycle) value.
- No handshake; inputs are assumed synchronous to `clk`.

## Structure
- Package `sseg_pkg` holds:
  - the 16 segment constants `SEG_0`..`SEG_F`
  - `SEG_BLANK`=7'h7F and `AN_OFF`=4'hF
  - the digit-index type (2-bit)
- Sub-module `hex_to_sseg`: combinational 4-bit → 7-bit decode, instantiated once on the muxed nibble.
- Top level contains the prescaler, index, snapshot, blanking logic and output registers.

## Test plan
Run all scenarios with REFRESH_DIV=4.
- **Reset and first frame:** reset low 3 cycles, `display_value`=32'h0000_1234, half_sel=0, blank_en=0 → outputs 1111/1111111 during reset and at edge 1. Edge 2: anode 1110 with cathode for "4". Then every 4 cycles: 1101 "3", 1011 "2", 0111 "1". `frame_tick` pulses at edge 2 and at edge 18.
- **Half select:** `display_value`=32'hABCD_0000, half_sel=1 → digits 0..3 show D, C, b, A.
- **Blanking:** value 16'h0008, blank_en=1 → digit 0 shows 0000000 (the "8" pattern). Anodes for digits 1–3 stay high for their full slots. Value 0 with blank_en=1 → digit 0 shows "0".
- **Snapshot stability:** change `display_value` from 32'h1111 to 32'hFFFF while digit 1 is lit → remainder of the frame shows "1". The next frame shows "F" (0001110) on all digits.
- **Mid-frame reset:** assert reset while digit 2 is lit → anode goes to 1111 without waiting for a clock edge. After release, the first-frame sequence of scenario 1 repeats exactly.
- **One-hot check:** over 3 full frames with random values, exactly one `sseg_anode` bit is low at any time, except when blanked (none low) and during the blank pre-frame after reset.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Segment patterns are active-low {g,f,e,d,c,b,a}; anodes are active-low.
// Pure declarations, no logic.
package sseg_pkg;

  // Index of the digit currently being scanned, 0 = rightmost.
  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  // All segments dark, all digits disabled.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

endpackage

// File: rtl/sseg_scan_driver_hex_to_sseg.sv
// Hex nibble to seven-segment pattern decoder (full 0-F set).
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of the input nibble.
module hex_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  // Lookup of the active-low segment pattern for the nibble.
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_nibble)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sseg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with frame-stable snapshot.
// Latency: outputs lag the digit index by one cycle; first digit lit on edge 2 after reset.
// Backpressure: none; free-running scan, inputs sampled only at snapshot load.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] display_value,
  input  logic        half_sel,
  input  logic        blank_en,
  output logic [6:0]  sseg_cathode,
  output logic [3:0]  sseg_anode,
  output logic        frame_tick
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] r_presc;
  digit_idx_t    r_idx;
  logic [15:0]   r_snap;
  logic          r_blank;
  logic          r_pending;
  logic          r_load_d;
  logic          r_frame_tick;
  logic [3:0]    r_anode;
  logic [6:0]    r_cathode;

  logic          w_tick;
  logic          w_load;
  logic [15:0]   w_half;
  logic [3:0]    w_nibble;
  logic [6:0]    w_seg;
  logic          w_digit_blank;
  logic [3:0]    w_anode_on;

  // The prescaler is frozen until the first snapshot exists, so digit 0
  // gets its full slot starting from the first lit cycle.
  assign w_tick = !r_pending && (r_presc == P_LAST);
  assign w_load = r_pending || (w_tick && (r_idx == 2'd3));
  assign w_half = half_sel ? display_value[31:16] : display_value[15:0];
  assign w_anode_on = ~(4'b0001 << r_idx);

  // Select the snapshot nibble for the digit being scanned.
  always_comb begin
    w_nibble = r_snap[3:0];
    case (r_idx)
      2'd1: w_nibble = r_snap[7:4];
      2'd2: w_nibble = r_snap[11:8];
      2'd3: w_nibble = r_snap[15:12];
      default: w_nibble = r_snap[3:0];
    endcase
  end

  // Leading-zero blanking: a digit is dark when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    w_digit_blank = 1'b0;
    case (r_idx)
      2'd1: w_digit_blank = (r_snap[15:4] == 12'h000);
      2'd2: w_digit_blank = (r_snap[15:8] == 8'h00);
      2'd3: w_digit_blank = (r_snap[15:12] == 4'h0);
      default: w_digit_blank = 1'b0;
    endcase
    w_digit_blank = w_digit_blank && r_blank;
  end

  hex_to_sseg u_hex_to_sseg (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  // Prescaler and digit index advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
      r_idx   <= 2'd0;
    end else if (!r_pending) begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) begin
        r_idx <= r_idx + 2'd1;
      end
    end
  end

  // Snapshot latch: once after reset release, then at every frame wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_snap    <= 16'h0000;
      r_blank   <= 1'b0;
      r_pending <= 1'b1;
    end else if (w_load) begin
      r_snap    <= w_half;
      r_blank   <= blank_en;
      r_pending <= 1'b0;
    end
  end

  // Frame pulse delayed two stages so it coincides with digit 0 appearing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_load_d     <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_load_d     <= w_load;
      r_frame_tick <= r_load_d;
    end
  end

  // Registered pad drivers; dark while no snapshot has been taken yet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_anode   <= AN_OFF;
      r_cathode <= SEG_BLANK;
    end else if (r_pending || w_digit_blank) begin
      r_anode   <= AN_OFF;
      r_cathode <= SEG_BLANK;
    end else begin
      r_anode   <= w_anode_on;
      r_cathode <= w_seg;
    end
  end

  assign sseg_anode   = r_anode;
  assign sseg_cathode = r_cathode;
  assign frame_tick   = r_frame_tick;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench for sseg_scan_driver with REFRESH_DIV=4.
// Edge e counts rising edges after reset release; outputs sampled 1 ns after each edge.
// Each scenario task drives stimulus and compares inline against hand-derived values.
module tb_sseg_scan_driver;

  logic        clk;
  logic        reset;
  logic [31:0] display_value;
  logic        half_sel;
  logic        blank_en;
  logic [6:0]  sseg_cathode;
  logic [3:0]  sseg_anode;
  logic        frame_tick;

  int n_checks;
  int n_fail;

  sseg_scan_driver #(.REFRESH_DIV(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .display_value (display_value),
    .half_sel      (half_sel),
    .blank_en      (blank_en),
    .sseg_cathode  (sseg_cathode),
    .sseg_anode    (sseg_anode),
    .frame_tick    (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written active-low {g,f,e,d,c,b,a} patterns.
  function automatic logic [6:0] exp_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for three edges with the given inputs, release just after an edge.
  task automatic apply_reset(input logic [31:0] v, input logic hs, input logic be);
    reset = 1'b0;
    display_value = v;
    half_sel = hs;
    blank_en = be;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    logic [3:0]  ea;
    logic [6:0]  ec;
    logic        et;
    int d;
    reset = 1'b0;
    display_value = 32'h0000_1234;
    half_sel = 1'b0;
    blank_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (sseg_anode !== 4'b1111 || sseg_cathode !== 7'b1111111 || frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: got an=%b cat=%b tick=%b want 1111/1111111/0", sseg_anode, sseg_cathode, frame_tick);
    end
    reset = 1'b1;
    step();
    n_checks++;
    if (sseg_anode !== 4'b1111 || sseg_cathode !== 7'b1111111 || frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_edge1: got an=%b cat=%b tick=%b want 1111/1111111/0", sseg_anode, sseg_cathode, frame_tick);
    end
    v = 16'h1234;
    for (int e = 2; e <= 18; e++) begin
      step();
      d = ((e - 2) / 4) % 4;
      ea = 4'b1111;
      ea[d] = 1'b0;
      ec = exp_seg(v[4*d +: 4]);
      et = (e == 2) || (e == 18);
      n_checks++;
      if (sseg_anode !== ea || sseg_cathode !== ec || frame_tick !== et) begin
        n_fail++;
        $display("FAIL first_frame e%0d: got an=%b cat=%b tick=%b want %b/%b/%b", e, sseg_anode, sseg_cathode, frame_tick, ea, ec, et);
      end
    end
  endtask

  task automatic test_half_sel();
    logic [15:0] v;
    logic [3:0]  ea;
    logic [6:0]  ec;
    int d;
    apply_reset(32'hABCD_0000, 1'b1, 1'b0);
    step();
    v = 16'hABCD;
    for (int e = 2; e <= 17; e++) begin
      step();
      d = ((e - 2) / 4) % 4;
      ea = 4'b1111;
      ea[d] = 1'b0;
      ec = exp_seg(v[4*d +: 4]);
      n_checks++;
      if (sseg_anode !== ea || sseg_cathode !== ec) begin
        n_fail++;
        $display("FAIL half_sel e%0d: got an=%b cat=%b want %b/%b", e, sseg_anode, sseg_cathode, ea, ec);
      end
    end
  endtask

  task automatic test_blanking();
    logic [3:0] ea;
    logic [6:0] ec;
    int d;
    apply_reset(32'h0000_0008, 1'b0, 1'b1);
    step();
    for (int e = 2; e <= 33; e++) begin
      step();
      d = ((e - 2) / 4) % 4;
      if (d == 0) begin
        ea = 4'b1110;
        ec = (e < 18) ? 7'b0000000 : 7'b1000000;
      end else begin
        ea = 4'b1111;
        ec = 7'b1111111;
      end
      n_checks++;
      if (sseg_anode !== ea || sseg_cathode !== ec) begin
        n_fail++;
        $display("FAIL blanking e%0d: got an=%b cat=%b want %b/%b", e, sseg_anode, sseg_cathode, ea, ec);
      end
      if (e == 2) display_value = 32'h0000_0000;
    end
  endtask

  task automatic test_snapshot();
    logic [15:0] v;
    logic [3:0]  ea;
    logic [6:0]  ec;
    logic        et;
    int d;
    apply_reset(32'h0000_1111, 1'b0, 1'b0);
    step();
    for (int e = 2; e <= 37; e++) begin
      step();
      v = (e < 18) ? 16'h1111 : (e < 34) ? 16'hFFFF : 16'h2222;
      d = ((e - 2) / 4) % 4;
      ea = 4'b1111;
      ea[d] = 1'b0;
      ec = exp_seg(v[4*d +: 4]);
      et = (e == 2) || (e == 18) || (e == 34);
      n_checks++;
      if (sseg_anode !== ea || sseg_cathode !== ec || frame_tick !== et) begin
        n_fail++;
        $display("FAIL snapshot e%0d: got an=%b cat=%b tick=%b want %b/%b/%b", e, sseg_anode, sseg_cathode, frame_tick, ea, ec, et);
      end
      // Change while digit 1 is lit, then exactly at the frame-wrap cycle.
      if (e == 6)  display_value = 32'h0000_FFFF;
      if (e == 32) display_value = 32'h0000_2222;
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] v;
    logic [3:0]  ea;
    logic [6:0]  ec;
    logic        et;
    int d;
    apply_reset(32'h0000_1234, 1'b0, 1'b0);
    for (int e = 1; e <= 10; e++) step();
    n_checks++;
    if (sseg_anode !== 4'b1011) begin
      n_fail++;
      $display("FAIL mid_reset_pre: got an=%b want 1011", sseg_anode);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (sseg_anode !== 4'b1111 || sseg_cathode !== 7'b1111111 || frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_async: got an=%b cat=%b tick=%b want 1111/1111111/0", sseg_anode, sseg_cathode, frame_tick);
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    step();
    n_checks++;
    if (sseg_anode !== 4'b1111 || sseg_cathode !== 7'b1111111 || frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_edge1: got an=%b cat=%b tick=%b want 1111/1111111/0", sseg_anode, sseg_cathode, frame_tick);
    end
    v = 16'h1234;
    for (int e = 2; e <= 18; e++) begin
      step();
      d = ((e - 2) / 4) % 4;
      ea = 4'b1111;
      ea[d] = 1'b0;
      ec = exp_seg(v[4*d +: 4]);
      et = (e == 2) || (e == 18);
      n_checks++;
      if (sseg_anode !== ea || sseg_cathode !== ec || frame_tick !== et) begin
        n_fail++;
        $display("FAIL mid_reset_frame e%0d: got an=%b cat=%b tick=%b want %b/%b/%b", e, sseg_anode, sseg_cathode, frame_tick, ea, ec, et);
      end
    end
  endtask

  task automatic test_onehot();
    logic [3:0] lows;
    int d;
    apply_reset($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    step();
    for (int e = 2; e <= 49; e++) begin
      step();
      d = ((e - 2) / 4) % 4;
      lows = ~sseg_anode;
      n_checks++;
      if ($countones(lows) > 1) begin
        n_fail++;
        $display("FAIL onehot e%0d: got an=%b want at most one low bit", e, sseg_anode);
      end
      n_checks++;
      if (sseg_anode === 4'b1111 && sseg_cathode !== 7'b1111111) begin
        n_fail++;
        $display("FAIL onehot_dark e%0d: got cat=%b want 1111111", e, sseg_cathode);
      end
      n_checks++;
      if (d == 0 && sseg_anode !== 4'b1110) begin
        n_fail++;
        $display("FAIL onehot_digit0 e%0d: got an=%b want 1110", e, sseg_anode);
      end
      display_value = $urandom;
      half_sel = 1'($urandom_range(0, 1));
      blank_en = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b0;
    display_value = 32'h0;
    half_sel = 1'b0;
    blank_en = 1'b0;
    test_reset();
    test_half_sel();
    test_blanking();
    test_snapshot();
    test_mid_reset();
    test_onehot();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
